ve_wb_buffer: RTL and testbench

Write-back buffer downstream of the vector-scalar ALU. It accepts 192-bit lane results (24 × 8-bit lanes) with a destination vector-register index. It queues them in a small FIFO and drains them to the vector register file write port under a ready handshake. It also reports read-after-write hazards against pending entries, so issue logic can stall. Results whose write-enable (the ALU's `flag`) is low are accepted but discarded.

---
 rtl/ve_wb_buffer.sv | 127 ++++++++++++
 tb/tb_ve_wb_buffer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ve_wb_buffer.sv
// ve_wb_buffer
// Write-back buffer between the vector-scalar ALU and the vector register
// file write port. Results are queued in a small circular FIFO and drained
// under a ready handshake. Results with in_we low are accepted and dropped.
// The buffer also reports read-after-write hazards against stored entries.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where valid and ready are both high.
//   Ready never depends combinationally on the valid of the same interface.
//   Input side : in_valid / in_ready  (in_ready = !full, registered state only)
//   Output side: wb_en    / wb_ready  (wb_en    = !empty, show-ahead head)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_ready    ALU result handshake
//   in_we, in_rd, in_data write-enable, destination register, 192-bit result
//   wb_en, wb_addr,       head entry (zeroed when empty)
//   wb_data, wb_ready     register file accept
//   flush                 synchronous clear of all entries
//   rd_query, hazard      RAW hazard lookup against stored entries
//   count, full, empty    occupancy status
module ve_wb_buffer #(
  parameter int DEPTH = 4,
  parameter int VLEN  = 192,
  parameter int RAW   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_we,
  input  logic [RAW-1:0]           in_rd,
  input  logic [VLEN-1:0]          in_data,
  output logic                     wb_en,
  output logic [RAW-1:0]           wb_addr,
  output logic [VLEN-1:0]          wb_data,
  input  logic                     wb_ready,
  input  logic                     flush,
  input  logic [RAW-1:0]           rd_query,
  output logic                     hazard,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [RAW-1:0]  rd_mem   [DEPTH];
  logic [VLEN-1:0] data_mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic push;
  logic pop;
  logic hazard_c;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  assign wb_en    = !empty;
  assign count    = count_q;

  // Flush suppresses both storage and pointer movement; the input handshake
  // still completes, the data is simply not kept.
  assign push = in_valid && in_ready && in_we && !flush;
  assign pop  = wb_en && wb_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is not reset; validity is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr_q]   <= in_rd;
      data_mem[wr_ptr_q] <= in_data;
    end
  end

  assign wb_addr = wb_en ? rd_mem[rd_ptr_q]   : '0;
  assign wb_data = wb_en ? data_mem[rd_ptr_q] : '0;

  // Slot i holds a live entry when its distance from the read pointer
  // (modulo DEPTH) is below the occupancy count.
  always_comb begin
    logic [PW-1:0] offset;
    hazard_c = 1'b0;
    offset   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PW'(i) - rd_ptr_q;
      if (({1'b0, offset} < count_q) && (rd_mem[i] == rd_query)) hazard_c = 1'b1;
    end
  end

  assign hazard = hazard_c;

endmodule

// File: tb/tb_ve_wb_buffer.sv
module tb_ve_wb_buffer;

  localparam int DEPTH = 4;
  localparam int VLEN  = 192;
  localparam int RAW   = 4;
  localparam int W     = RAW + VLEN;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            in_valid, in_ready, in_we;
  logic [RAW-1:0]  in_rd;
  logic [VLEN-1:0] in_data;
  logic            wb_en;
  logic [RAW-1:0]  wb_addr;
  logic [VLEN-1:0] wb_data;
  logic            wb_ready, flush;
  logic [RAW-1:0]  rd_query;
  logic            hazard;
  logic [$clog2(DEPTH):0] count;
  logic            full, empty;

  ve_wb_buffer #(.DEPTH(DEPTH), .VLEN(VLEN), .RAW(RAW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we),
    .in_rd(in_rd), .in_data(in_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .flush(flush), .rd_query(rd_query), .hazard(hazard),
    .count(count), .full(full), .empty(empty)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VLEN-1:0] lanes(input logic [7:0] b);
    return {24{b}};
  endfunction

  // ---------------- driver tasks ----------------
  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_we = 1'b0; in_rd = '0; in_data = '0;
    wb_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic push(input logic [RAW-1:0] rd, input logic [VLEN-1:0] d);
    in_valid = 1'b1; in_we = 1'b1; in_rd = rd; in_data = d;
    step();
    exp_q.push_back({rd, d});
    in_valid = 1'b0; in_we = 1'b0;
  endtask

  // Check the head against the scoreboard then pop it on the next edge.
  task automatic drain_one(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, W'(0), W'(1));
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_en"}, W'(wb_en), W'(1));
      chk({tag, "_head"}, {wb_addr, wb_data}, e);
    end
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_empty"},   W'(empty),    W'(1));
    chk({tag, "_wb_en"},   W'(wb_en),    W'(0));
    chk({tag, "_count"},   W'(count),    W'(0));
    chk({tag, "_head0"},   {wb_addr, wb_data}, W'(0));
    chk({tag, "_inready"}, W'(in_ready), W'(1));
    chk({tag, "_full"},    W'(full),     W'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    rd_query = '0;
    rst_n = 1'b0;

    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    chk_empty("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_empty("rst_idle");
    chk("rst_hazard", W'(hazard), W'(0));

    // Fill then drain
    for (int i = 1; i <= 4; i++) push(RAW'(i), lanes(8'(8'h11 * i)));
    chk("fill_full",    W'(full),     W'(1));
    chk("fill_inready", W'(in_ready), W'(0));
    chk("fill_count",   W'(count),    W'(4));
    in_valid = 1'b1; in_we = 1'b1; in_rd = 4'd9; in_data = lanes(8'h55);
    step();
    in_valid = 1'b0; in_we = 1'b0;
    chk("fifth_count", W'(count), W'(4));
    rd_query = 4'd3; #1;
    chk("fill_hz_3", W'(hazard), W'(1));
    rd_query = 4'd9; #1;
    chk("fill_hz_9", W'(hazard), W'(0));
    for (int i = 0; i < 4; i++) drain_one($sformatf("drain%0d", i));
    wb_ready = 1'b1;  // ignored while empty
    step();
    wb_ready = 1'b0;
    chk_empty("drained");

    // Discard and hazard
    in_valid = 1'b1; in_we = 1'b0; in_rd = 4'd5; in_data = lanes(8'h5a);
    step();
    chk("discard_count", W'(count), W'(0));
    push(4'd7, lanes(8'h77));
    chk("discard_count2", W'(count), W'(1));
    rd_query = 4'd7; #1;
    chk("hz_7", W'(hazard), W'(1));
    rd_query = 4'd5; #1;
    chk("hz_5", W'(hazard), W'(0));
    // An incoming result targeting rd_query is not yet stored.
    in_valid = 1'b1; in_we = 1'b1; in_rd = 4'd5; #1;
    chk("hz_incoming", W'(hazard), W'(0));
    in_valid = 1'b0; in_we = 1'b0;

    // Simultaneous push/pop with pointer wrap
    push(4'd8, lanes(8'h88));
    chk("pp_count0", W'(count), W'(2));
    for (int i = 0; i < 10; i++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      chk($sformatf("pp_head%0d", i), {wb_addr, wb_data}, e);
      if (i == 0) begin
        // The entry popping this cycle still counts as a hazard.
        rd_query = e[W-1 -: RAW]; #1;
        chk("pp_hz_popping", W'(hazard), W'(1));
      end
      in_valid = 1'b1; in_we = 1'b1; wb_ready = 1'b1;
      in_rd = RAW'(i); in_data = VLEN'(i);
      step();
      exp_q.push_back({RAW'(i), VLEN'(i)});
      chk($sformatf("pp_count%0d", i + 1), W'(count), W'(2));
    end
    in_valid = 1'b0; in_we = 1'b0; wb_ready = 1'b0;
    drain_one("pp_tail0");
    drain_one("pp_tail1");
    chk_empty("pp_done");

    // Flush versus push and pop
    push(4'd1, lanes(8'ha1));
    push(4'd2, lanes(8'ha2));
    push(4'd3, lanes(8'ha3));
    chk("fl_count3", W'(count), W'(3));
    flush = 1'b1; in_valid = 1'b1; in_we = 1'b1; in_rd = 4'd4;
    in_data = lanes(8'ha4); wb_ready = 1'b1;
    #1;
    chk("fl_inready", W'(in_ready), W'(1));
    step();
    flush = 1'b0; in_valid = 1'b0; in_we = 1'b0;
    exp_q.delete();
    chk_empty("fl_after");
    rd_query = 4'd4; #1;
    chk("fl_hz_4", W'(hazard), W'(0));
    rd_query = 4'd1; #1;
    chk("fl_hz_1", W'(hazard), W'(0));
    step();
    chk("fl_no_write", W'(wb_en), W'(0));
    wb_ready = 1'b0;
    push(4'd6, lanes(8'h66));
    drain_one("fl_restart");
    chk_empty("fl_restart_done");

    // Asynchronous reset mid-drain
    push(4'ha, lanes(8'hba));
    push(4'hb, lanes(8'hbb));
    chk("ar_count2", W'(count), W'(2));
    wb_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk_empty("ar_now");
    rd_query = 4'ha; #1;
    chk("ar_hz", W'(hazard), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_empty("ar_released");
    step();
    chk("ar_no_write", W'(wb_en), W'(0));
    wb_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
